pc_gen_pipe: RTL
================

# pc_gen_pipe

Parametrised program-counter generator for the pipelined 32b MIPS core, succeeding the single-cycle PC unit. Sits in IF and produces the fetch address under an instruction-memory valid/ready handshake. Accepts stalls from the hazard unit and late redirects (BEQ, J, JR) from EX. Adds a configurable reset vector and halt address, resume-from-halt, and a fault state for misaligned register jumps.

## Interface
Parameters:
- XLEN, 32, PC/data width; must be ≥ 32.
- RESET_PC, 32'h0, value loaded into cur_pc by reset; must be word-aligned.
- HALT_EN, 1, enables halt detection.
- HALT_PC_WORD, 3, word index (target >> 2) that triggers halt.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  hazard unit: hold PC
- redirect_valid  in  1  EX resolved a control transfer this cycle
- redirect_kind  in  2  pc_pkg::redir_e: BR=0, J=1, JR=2 (3 reserved, treated as no redirect)
- redirect_pc4  in  XLEN  PC+4 of the redirecting instruction
- br_offset  in  XLEN  sign-extended BEQ immediate
- jmp_imm  in  26  J-type immediate
- jr_target  in  XLEN  register value for JR
- resume  in  1  leave HALTED
- if_ready  in  1  instruction memory accepts address
- if_valid  out  1  cur_pc is a live fetch request
- cur_pc  out  XLEN  registered fetch address
- nxt_pc  out  XLEN  combinational next-PC candidate
- flush  out  1  one-cycle pulse: younger IF/ID instructions invalid
- pc_halted  out  1  state == HALTED
- pc_fault  out  1  state == FAULT

## Operation
- States (pc_pkg::pc_state_e): RUN, HALTED, FAULT. Reset → RUN.
- Targets (mod 2^XLEN): BR = redirect_pc4 + (br_offset << 2); J = {redirect_pc4[XLEN-1:28], jmp_imm, 2'b00}; JR = jr_target; SEQ = cur_pc + 4.
- nxt_pc priority in RUN: redirect_valid (kinds 0-2) > stall → cur_pc > (if_valid & if_ready) → SEQ > cur_pc.
- Redirect wins over stall and ignores if_ready; it abandons any unaccepted fetch. flush = redirect taken in RUN.
- JR with jr_target[1:0] != 0: no PC update, go to FAULT, flush=1. FAULT exits only via rst.
- Halt (HALT_EN=1): if RUN and nxt_pc != cur_pc and (nxt_pc >> 2) == HALT_PC_WORD → cur_pc holds, nxt_pc latched into halt_tgt, state HALTED.
- HALTED: if_valid=0; cur_pc frozen; stall and redirect ignored. resume → cur_pc <= halt_tgt, state RUN, no halt check on that load.
- if_valid = (state == RUN) & !stall & !rst.

## Timing
- Reset values: cur_pc=RESET_PC, halt_tgt=RESET_PC, state RUN, if_valid=0 during rst, flush=0, pc_halted=0, pc_fault=0.
- First request: if_valid=1 in the cycle after rst deasserts.
- cur_pc updates at the edge following the qualifying condition, so latency is 1 cycle from redirect/accept to the new cur_pc.
- nxt_pc, flush and if_valid are combinational from current inputs/state. pc_halted and pc_fault are registered.
- Simultaneous redirect and halt match: halt wins. Redirect target is latched into halt_tgt.
- Simultaneous resume and rst: rst wins.
- rst mid-stall, mid-halt or in FAULT: returns to reset values next edge.
- Wrap-around: cur_pc = 2^XLEN-4 with accepted fetch → 0, no error.

## Structure
- pc_pkg holds redir_e, pc_state_e and a localparam for WORD_SHIFT=2.
- One sub-module, pc_target_calc (combinational): computes BR/J/JR/SEQ targets and the JR-misaligned flag, parametrised by XLEN.
- pc_gen_pipe holds the state register, cur_pc, halt_tgt and the priority mux.

## Test plan
- Reset release, if_ready=1, HALT_EN=0: cur_pc 0→4→8→C on consecutive cycles. With if_ready=0, cur_pc holds at 0 and if_valid=1.
- stall=1 and redirect BR (redirect_pc4=0x20, br_offset=-2) in the same cycle: next cur_pc=0x18, flush=1 for one cycle.
- J with redirect_pc4=0x40000010, jmp_imm=0x10: cur_pc=0x40000040. JR to 0x102: pc_fault=1, cur_pc unchanged, stays faulted until rst.
- Default halt: from 0, cur_pc stops at 8 and pc_halted=1. resume → cur_pc=0xC, pc_halted=0, execution continues to 0x10.
- XLEN=32, RESET_PC=0xFFFFFFF8, HALT_EN=0: cur_pc FFFFFFF8→FFFFFFFC→0. Asserting rst while halted restores RESET_PC.

Source files
------------

// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the pipelined program-counter generator.
//   redir_e     : kind of control transfer resolved in EX (BR, J, JR, reserved)
//   pc_state_e  : PC generator state (RUN, HALTED, FAULT)
//   WORD_SHIFT  : log2 of the instruction size in bytes
//   is_word_aligned() : true when the two low address bits are zero
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int WORD_SHIFT = 2;

    typedef enum logic [1:0] {
        REDIR_BR   = 2'd0,
        REDIR_J    = 2'd1,
        REDIR_JR   = 2'd2,
        REDIR_RSVD = 2'd3
    } redir_e;

    typedef enum logic [1:0] {
        PC_RUN    = 2'd0,
        PC_HALTED = 2'd1,
        PC_FAULT  = 2'd2
    } pc_state_e;

    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc
// Purely combinational target arithmetic for the PC generator.
// Ports:
//   i_cur_pc        : current fetch address (for the sequential target)
//   i_redirect_pc4  : PC+4 of the redirecting instruction in EX
//   i_br_offset     : sign-extended BEQ immediate (word offset)
//   i_jmp_imm       : 26-bit J-type immediate
//   i_jr_target     : register value used by JR
//   o_br_target     : redirect_pc4 + (br_offset << 2)
//   o_j_target      : {redirect_pc4[XLEN-1:28], jmp_imm, 2'b00}
//   o_jr_target     : jr_target passed through
//   o_seq_target    : cur_pc + 4
//   o_jr_misaligned : JR target is not word aligned
// All sums wrap modulo 2^XLEN.
// ---------------------------------------------------------------------------
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_cur_pc,
    input  logic [XLEN-1:0] i_redirect_pc4,
    input  logic [XLEN-1:0] i_br_offset,
    input  logic [25:0]     i_jmp_imm,
    input  logic [XLEN-1:0] i_jr_target,
    output logic [XLEN-1:0] o_br_target,
    output logic [XLEN-1:0] o_j_target,
    output logic [XLEN-1:0] o_jr_target,
    output logic [XLEN-1:0] o_seq_target,
    output logic            o_jr_misaligned
);

    localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(1) << WORD_SHIFT;

    // Branch offset is in words, so scale it to bytes before adding.
    assign o_br_target     = i_redirect_pc4 + (i_br_offset << WORD_SHIFT);

    // Jumps stay inside the 256 MB region of the delay-slot PC.
    assign o_j_target      = {i_redirect_pc4[XLEN-1:28], i_jmp_imm, 2'b00};

    assign o_jr_target     = i_jr_target;
    assign o_seq_target    = i_cur_pc + INSN_BYTES;
    assign o_jr_misaligned = !is_word_aligned(i_jr_target[1:0]);

endmodule

// File: rtl/pc_gen_pipe.sv
// ---------------------------------------------------------------------------
// pc_gen_pipe
// Program-counter generator for the IF stage of the pipelined MIPS core.
// Issues fetch addresses under a valid/ready handshake, holds on stalls,
// takes late redirects (BEQ/J/JR) from EX, halts on a configurable word
// address and resumes on request, and traps misaligned JR targets.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   stall           : hazard unit hold request
//   redirect_valid  : EX resolved a control transfer this cycle
//   redirect_kind   : redir_e encoding (BR=0, J=1, JR=2, 3 ignored)
//   redirect_pc4    : PC+4 of the redirecting instruction
//   br_offset       : sign-extended BEQ immediate
//   jmp_imm         : J-type immediate
//   jr_target       : register value for JR
//   resume          : leave HALTED
//   if_ready        : instruction memory accepts the address
//   if_valid        : cur_pc is a live fetch request
//   cur_pc          : registered fetch address
//   nxt_pc          : combinational next-PC candidate
//   flush           : younger IF/ID instructions are invalid this cycle
//   pc_halted       : generator is in HALTED
//   pc_fault        : generator is in FAULT
// ---------------------------------------------------------------------------
module pc_gen_pipe
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter bit              HALT_EN      = 1'b1,
    parameter int              HALT_PC_WORD = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [1:0]      redirect_kind,
    input  logic [XLEN-1:0] redirect_pc4,
    input  logic [XLEN-1:0] br_offset,
    input  logic [25:0]     jmp_imm,
    input  logic [XLEN-1:0] jr_target,
    input  logic            resume,
    input  logic            if_ready,
    output logic            if_valid,
    output logic [XLEN-1:0] cur_pc,
    output logic [XLEN-1:0] nxt_pc,
    output logic            flush,
    output logic            pc_halted,
    output logic            pc_fault
);

    localparam logic [XLEN-1:0] HALT_WORD = XLEN'(HALT_PC_WORD);

    pc_state_e       r_state;
    logic [XLEN-1:0] r_cur_pc;
    logic [XLEN-1:0] r_halt_tgt;

    redir_e          w_kind;
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_j_target;
    logic [XLEN-1:0] w_jr_target;
    logic [XLEN-1:0] w_seq_target;
    logic            w_jr_misaligned;
    logic            w_running;
    logic            w_redir_take;
    logic            w_jr_fault;
    logic            w_fetch_accept;
    logic            w_halt_hit;
    logic [XLEN-1:0] w_nxt_pc;

    assign w_kind = redir_e'(redirect_kind);

    pc_target_calc #(
        .XLEN (XLEN)
    ) u_target_calc (
        .i_cur_pc        (r_cur_pc),
        .i_redirect_pc4  (redirect_pc4),
        .i_br_offset     (br_offset),
        .i_jmp_imm       (jmp_imm),
        .i_jr_target     (jr_target),
        .o_br_target     (w_br_target),
        .o_j_target      (w_j_target),
        .o_jr_target     (w_jr_target),
        .o_seq_target    (w_seq_target),
        .o_jr_misaligned (w_jr_misaligned)
    );

    // Redirects only count while running; the reserved kind is a no-op.
    assign w_running      = (r_state == PC_RUN);
    assign w_redir_take   = w_running && redirect_valid && (w_kind != REDIR_RSVD);
    assign w_jr_fault     = w_redir_take && (w_kind == REDIR_JR) && w_jr_misaligned;

    assign if_valid       = w_running && !stall && !rst;
    assign w_fetch_accept = if_valid && if_ready;

    // Next-PC priority: redirect beats stall (and ignores if_ready, which
    // drops any outstanding unaccepted fetch), then stall holds, then an
    // accepted fetch advances sequentially. A misaligned JR leaves the
    // candidate at cur_pc since the PC must not move on a fault.
    always_comb begin
        w_nxt_pc = r_cur_pc;
        case (r_state)
            PC_RUN: begin
                if (w_redir_take) begin
                    case (w_kind)
                        REDIR_BR: w_nxt_pc = w_br_target;
                        REDIR_J:  w_nxt_pc = w_j_target;
                        REDIR_JR: w_nxt_pc = w_jr_misaligned ? r_cur_pc : w_jr_target;
                        default:  w_nxt_pc = r_cur_pc;
                    endcase
                end else if (stall) begin
                    w_nxt_pc = r_cur_pc;
                end else if (w_fetch_accept) begin
                    w_nxt_pc = w_seq_target;
                end
            end
            PC_HALTED: begin
                if (resume) begin
                    w_nxt_pc = r_halt_tgt;
                end
            end
            default: w_nxt_pc = r_cur_pc;
        endcase
    end

    // Halt fires on an actual move onto the halt word; a redirect landing
    // there halts too, with the redirect target remembered for resume.
    assign w_halt_hit = HALT_EN && w_running && !w_jr_fault &&
                        (w_nxt_pc != r_cur_pc) &&
                        ((w_nxt_pc >> WORD_SHIFT) == HALT_WORD);

    // State, fetch address and halt target. Reset dominates resume, and
    // FAULT is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= PC_RUN;
            r_cur_pc   <= RESET_PC;
            r_halt_tgt <= RESET_PC;
        end else begin
            case (r_state)
                PC_RUN: begin
                    if (w_jr_fault) begin
                        r_state <= PC_FAULT;
                    end else if (w_halt_hit) begin
                        r_halt_tgt <= w_nxt_pc;
                        r_state    <= PC_HALTED;
                    end else begin
                        r_cur_pc <= w_nxt_pc;
                    end
                end
                PC_HALTED: begin
                    if (resume) begin
                        r_cur_pc <= r_halt_tgt;
                        r_state  <= PC_RUN;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign cur_pc    = r_cur_pc;
    assign nxt_pc    = w_nxt_pc;
    assign flush     = w_redir_take && !rst;
    assign pc_halted = (r_state == PC_HALTED);
    assign pc_fault  = (r_state == PC_FAULT);

endmodule
